nvram_uploader: RTL and testbench
=================================

NVRAM_UPLOADER -- requirements
Module: nvram_uploader

Interface
REQ-001 SHALL have parameter AW, default 10: byte-address width of the NVRAM/hiscore RAM being read.
REQ-002 SHALL have parameter INDEX, default 8'd4: ioctl_index value that selects this uploader.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 4096: maximum cycles to wait for pause_ack.
REQ-004 SHALL have port clk_sys, input, 1: the single clock for all logic.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port ioctl_upload, input, 1: HPS upload session active.
REQ-007 SHALL have port ioctl_index, input, 8: selected file index.
REQ-008 SHALL have port ioctl_rd, input, 1: one-cycle byte request.
REQ-009 SHALL have port ioctl_addr, input, 25: byte address of the request.
REQ-010 SHALL have port ioctl_din, output, 8: returned byte.
REQ-011 SHALL have port ioctl_wait, output, 1: high while the uploader cannot accept a request.
REQ-012 SHALL have port pause_req, output, 1: core CPU halt request.
REQ-013 SHALL have port pause_ack, input, 1: core confirms it is halted.
REQ-014 SHALL have port mem_addr, output, AW: RAM read address.
REQ-015 SHALL have port mem_rd, output, 1: RAM read strobe.
REQ-016 SHALL have port mem_q, input, 8: RAM data, valid one cycle after mem_rd.
REQ-017 SHALL have port ack_timeout, output, 1: sticky flag, set when pause_ack did not arrive in time.
REQ-018 SHALL have port byte_count, output, AW+1: number of bytes served in the current session.

Function
REQ-019 SHALL implement the states IDLE, PAUSE_WAIT, READY, ISSUE and CAPTURE.
REQ-020 SHALL leave IDLE for PAUSE_WAIT when ioctl_upload=1 and ioctl_index==INDEX; in that same cycle pause_req SHALL rise and byte_count SHALL clear to 0.
REQ-021 SHALL, in PAUSE_WAIT, go to READY on pause_ack=1, or after ACK_TIMEOUT cycles without pause_ack, in which case ack_timeout SHALL be set.
REQ-022 SHALL hold ioctl_wait=1 in PAUSE_WAIT, ISSUE and CAPTURE, and hold ioctl_wait=0 in IDLE and READY.
REQ-023 SHALL, on ioctl_rd=1 in READY, latch ioctl_addr and go to ISSUE.
REQ-024 SHALL, in ISSUE, drive mem_addr=latched addr[AW-1:0] with mem_rd=1 for exactly one cycle, then go to CAPTURE.
REQ-025 SHALL, in CAPTURE, register mem_q into ioctl_din, increment byte_count, and return to READY; ioctl_din is therefore valid 2 cycles after ioctl_rd.
REQ-026 SHALL treat an address >= 2**AW as out of range: mem_rd stays 0 and ioctl_din=8'hFF, with the same 2-cycle latency and the same byte_count increment.
REQ-027 SHALL ignore ioctl_rd in any state other than READY, with no queueing.
REQ-028 SHALL saturate byte_count at 2**AW and never let it wrap.
REQ-029 SHALL, when ioctl_upload falls in any non-IDLE state, abort within that cycle: go to IDLE, drop pause_req and mem_rd, and leave ioctl_din unchanged.
REQ-030 SHALL give precedence to ioctl_upload falling over an ioctl_rd in the same cycle; that request is dropped.
REQ-031 SHALL abort per REQ-029 if ioctl_index changes away from INDEX mid-session.
REQ-032 SHALL hold pause_req high continuously from PAUSE_WAIT until return to IDLE.
REQ-033 SHALL keep mem_rd=0 in every state except ISSUE.
REQ-034 SHALL clear ack_timeout only on reset.

Reset
REQ-035 SHALL, on reset, set: state=IDLE, ioctl_din=8'h00, ioctl_wait=0, pause_req=0, mem_rd=0, mem_addr=0, ack_timeout=0, byte_count=0, timeout counter=0.
REQ-036 SHALL apply reset asserted mid-read immediately, with no completion of the pending byte; after reset release the block SHALL need a fresh ioctl_upload rising edge before starting a session.

Structure
REQ-037 SHALL place the state enum and the default INDEX constant in the shared package mcr_ioctl_pkg.
REQ-038 SHALL contain no sub-module; the timeout counter is inline, sized $clog2(ACK_TIMEOUT+1).

Verification
REQ-039 SHALL cover the normal session: upload with index 4, pause_ack after 10 cycles, rd at addr 0x005 with RAM[5]=0xA5 -> ioctl_din=0xA5 exactly 2 cycles after rd, ioctl_wait high for 2 cycles, byte_count=1.
REQ-040 SHALL cover out-of-range: AW=10, rd at 0x400 -> mem_rd never asserted, ioctl_din=0xFF after 2 cycles.
REQ-041 SHALL cover ack timeout: pause_ack held 0 -> READY reached after 4096 cycles, ack_timeout=1 and still 1 after the session ends.
REQ-042 SHALL cover rd while busy: second rd one cycle after the first -> ignored, only one mem_rd pulse, byte_count=1.
REQ-043 SHALL cover abort: ioctl_upload dropped in the ISSUE cycle -> next cycle IDLE, pause_req=0, ioctl_din unchanged; a wrong index (5) -> pause_req never rises.
REQ-044 SHALL cover reset mid-CAPTURE: all outputs take their REQ-035 values asynchronously, before the next clk_sys edge.

Source files
------------

// File: rtl/mcr_ioctl_pkg.sv
// Shared definitions for the ioctl (HPS file-transfer) helpers of this core.
//   upl_state_t  : state encoding of the NVRAM/hiscore uploader
//   NVRAM_INDEX  : ioctl_index that selects the NVRAM uploader by default
//   OOR_BYTE     : value returned for addresses beyond the RAM
package mcr_ioctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE_WAIT,
    ST_READY,
    ST_ISSUE,
    ST_CAPTURE
  } upl_state_t;

  localparam logic [7:0] NVRAM_INDEX = 8'd4;
  localparam logic [7:0] OOR_BYTE    = 8'hFF;

endpackage

// File: rtl/nvram_uploader_if.sv
// HPS ioctl upload channel as seen by an uploader.
//   master : HPS side (drives upload/index/rd/addr, receives din/wait)
//   slave  : uploader side
interface nvram_uploader_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/nvram_uploader.sv
// NVRAM / hiscore uploader: serves HPS ioctl upload reads from a core RAM.
// A session halts the core CPU (pause_req/pause_ack), then each ioctl_rd is
// turned into one RAM read whose byte appears on ioctl_din two edges later.
//   clk_sys, reset              : clock, async active-high reset
//   ioctl_upload/index/rd/addr  : HPS request side
//   ioctl_din, ioctl_wait       : returned byte, busy indication
//   pause_req, pause_ack        : core halt handshake
//   mem_addr, mem_rd, mem_q     : RAM read port (mem_q one cycle after mem_rd)
//   ack_timeout                 : sticky, pause_ack never arrived in time
//   byte_count                  : bytes served this session, saturating
module nvram_uploader
  import mcr_ioctl_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter logic [7:0]  INDEX       = NVRAM_INDEX,
  parameter int unsigned ACK_TIMEOUT = 4096
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_q,
  output logic          ack_timeout,
  output logic [AW:0]   byte_count
);

  localparam int unsigned TW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [AW:0]   BC_MAX  = {1'b1, {AW{1'b0}}};

  upl_state_t    r_state;
  logic [TW-1:0] r_to_cnt;
  logic          r_armed;    // upload has been seen low since the last start
  logic          r_oor;      // latched request lies beyond the RAM
  logic [7:0]    r_din;
  logic          r_wait;
  logic          r_pause;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_rd;
  logic          r_ack_to;
  logic [AW:0]   r_bc;

  logic w_hit;
  logic w_in_range;

  assign w_hit      = ioctl_upload && (ioctl_index == INDEX);
  assign w_in_range = (ioctl_addr >> AW) == '0;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_to_cnt   <= '0;
      r_armed    <= 1'b0;
      r_oor      <= 1'b0;
      r_din      <= 8'h00;
      r_wait     <= 1'b0;
      r_pause    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_ack_to   <= 1'b0;
      r_bc       <= '0;
    end else begin
      // A session only starts from a rising upload edge, so a level left
      // high across reset or an abort cannot restart it on its own.
      if (!ioctl_upload) r_armed <= 1'b1;

      // Losing upload or the index wins over everything, including a
      // request arriving in the same cycle.
      if (r_state != ST_IDLE && !w_hit) begin
        r_state  <= ST_IDLE;
        r_pause  <= 1'b0;
        r_mem_rd <= 1'b0;
        r_wait   <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_hit && r_armed) begin
              r_state  <= ST_PAUSE_WAIT;
              r_armed  <= 1'b0;
              r_pause  <= 1'b1;
              r_wait   <= 1'b1;
              r_bc     <= '0;
              r_to_cnt <= '0;
            end
          end
          ST_PAUSE_WAIT: begin
            if (pause_ack) begin
              r_state <= ST_READY;
              r_wait  <= 1'b0;
            end else if (r_to_cnt == TO_LAST) begin
              // Proceed anyway; the flag tells software the dump may be torn.
              r_state  <= ST_READY;
              r_wait   <= 1'b0;
              r_ack_to <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          ST_READY: begin
            if (ioctl_rd) begin
              r_state    <= ST_ISSUE;
              r_wait     <= 1'b1;
              r_mem_addr <= ioctl_addr[AW-1:0];
              r_mem_rd   <= w_in_range;
              r_oor      <= !w_in_range;
            end
          end
          ST_ISSUE: begin
            r_state  <= ST_CAPTURE;
            r_mem_rd <= 1'b0;
          end
          ST_CAPTURE: begin
            r_din   <= r_oor ? OOR_BYTE : mem_q;
            r_state <= ST_READY;
            r_wait  <= 1'b0;
            if (r_bc != BC_MAX) r_bc <= r_bc + 1'b1;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_pause  <= 1'b0;
            r_mem_rd <= 1'b0;
            r_wait   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ioctl_din   = r_din;
  assign ioctl_wait  = r_wait;
  assign pause_req   = r_pause;
  assign mem_addr    = r_mem_addr;
  assign mem_rd      = r_mem_rd;
  assign ack_timeout = r_ack_to;
  assign byte_count  = r_bc;

endmodule

// File: tb/tb_nvram_uploader.sv
// Directed bench for nvram_uploader with a synchronous RAM model.
module tb_nvram_uploader;

  localparam int AW = 10;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          pause_ack;
  logic          pause_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_q = 8'h00;
  logic          ack_timeout;
  logic [AW:0]   byte_count;

  nvram_uploader_if hps ();

  nvram_uploader #(.AW(AW), .INDEX(8'd4), .ACK_TIMEOUT(4096)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (hps.ioctl_upload),
    .ioctl_index  (hps.ioctl_index),
    .ioctl_rd     (hps.ioctl_rd),
    .ioctl_addr   (hps.ioctl_addr),
    .ioctl_din    (hps.ioctl_din),
    .ioctl_wait   (hps.ioctl_wait),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_q        (mem_q),
    .ack_timeout  (ack_timeout),
    .byte_count   (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM model: ram[i] = i*7+3, except ram[5] = A5.
  logic [7:0] ram [0:(1<<AW)-1];
  int pulses = 0;
  always @(posedge clk_sys) begin
    if (mem_rd) begin
      mem_q  <= ram[mem_addr];
      pulses <= pulses + 1;
    end
  end

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    int          pulse;
  } vec_t;

  vec_t vecs [7];
  int total = 0;
  int bad   = 0;
  int bc_exp = 0;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic start_session(input int ack_delay);
    hps.ioctl_upload = 1'b1;
    hps.ioctl_index  = 8'd4;
    tick();
    chk("start_pause_req", 32'(pause_req), 1);
    chk("start_wait", 32'(hps.ioctl_wait), 1);
    chk("start_bc", 32'(byte_count), 0);
    bc_exp = 0;
    repeat (ack_delay - 1) tick();
    chk("pw_wait_held", 32'(hps.ioctl_wait), 1);
    pause_ack = 1'b1;
    tick();
    chk("ready_wait", 32'(hps.ioctl_wait), 0);
  endtask

  task automatic end_session();
    hps.ioctl_upload = 1'b0;
    pause_ack = 1'b0;
    tick();
    chk("end_pause_req", 32'(pause_req), 0);
  endtask

  task automatic do_read(input logic [24:0] a, input logic [7:0] exp_din, input int exp_pulse);
    int p0;
    logic [7:0] d0;
    p0 = pulses;
    d0 = hps.ioctl_din;
    hps.ioctl_rd   = 1'b1;
    hps.ioctl_addr = a;
    tick();
    hps.ioctl_rd = 1'b0;
    chk("issue_wait", 32'(hps.ioctl_wait), 1);
    chk("issue_mem_rd", 32'(mem_rd), 32'(exp_pulse));
    if (exp_pulse != 0) chk("issue_addr", 32'(mem_addr), 32'(a[AW-1:0]));
    tick();
    chk("capture_wait", 32'(hps.ioctl_wait), 1);
    chk("capture_mem_rd", 32'(mem_rd), 0);
    chk("capture_din_hold", 32'(hps.ioctl_din), 32'(d0));
    tick();
    chk("read_din", 32'(hps.ioctl_din), 32'(exp_din));
    chk("read_wait", 32'(hps.ioctl_wait), 0);
    chk("read_pulses", 32'(pulses - p0), 32'(exp_pulse));
    if (bc_exp < 1024) bc_exp++;
    chk("read_bc", 32'(byte_count), 32'(bc_exp));
  endtask

  initial begin
    int n;
    int p0;
    logic seen;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'(i * 7 + 3);
    ram[5] = 8'hA5;

    vecs[0] = '{25'h0000005, 8'hA5, 1};
    vecs[1] = '{25'h0000000, 8'h03, 1};
    vecs[2] = '{25'h00003FF, 8'hFC, 1};
    vecs[3] = '{25'h0000400, 8'hFF, 0};
    vecs[4] = '{25'h00002A0, 8'h63, 1};
    vecs[5] = '{25'h1FFFFFF, 8'hFF, 0};
    vecs[6] = '{25'h0000010, 8'h73, 1};

    reset = 1'b1;
    pause_ack = 1'b0;
    hps.ioctl_upload = 1'b0;
    hps.ioctl_index  = 8'd0;
    hps.ioctl_rd     = 1'b0;
    hps.ioctl_addr   = '0;
    tick();
    tick();
    chk("rst_din", 32'(hps.ioctl_din), 0);
    chk("rst_wait", 32'(hps.ioctl_wait), 0);
    chk("rst_pause", 32'(pause_req), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_ack_to", 32'(ack_timeout), 0);
    chk("rst_bc", 32'(byte_count), 0);
    reset = 1'b0;
    tick();

    // Wrong index never raises pause_req.
    hps.ioctl_upload = 1'b1;
    hps.ioctl_index  = 8'd5;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (pause_req) seen = 1'b1;
    end
    chk("wrong_index_pause", 32'(seen), 0);
    hps.ioctl_upload = 1'b0;
    tick();

    // Normal session and the vector table.
    start_session(10);
    for (int i = 0; i < 7; i++) do_read(vecs[i].addr, vecs[i].din, vecs[i].pulse);
    chk("no_ack_timeout", 32'(ack_timeout), 0);

    // Second rd while busy is dropped, not queued.
    p0 = pulses;
    hps.ioctl_rd = 1'b1;
    hps.ioctl_addr = 25'h000;
    tick();
    hps.ioctl_addr = 25'h005;
    tick();
    hps.ioctl_rd = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("busy_din", 32'(hps.ioctl_din), 32'h03);
    chk("busy_pulses", 32'(pulses - p0), 1);
    chk("busy_bc", 32'(byte_count), 8);

    // Abort in the ISSUE cycle.
    hps.ioctl_rd = 1'b1;
    hps.ioctl_addr = 25'h3FF;
    tick();
    hps.ioctl_rd = 1'b0;
    hps.ioctl_upload = 1'b0;
    pause_ack = 1'b0;
    tick();
    chk("abort_pause", 32'(pause_req), 0);
    chk("abort_mem_rd", 32'(mem_rd), 0);
    chk("abort_wait", 32'(hps.ioctl_wait), 0);
    chk("abort_din", 32'(hps.ioctl_din), 32'h03);
    tick();
    tick();
    chk("abort_din_later", 32'(hps.ioctl_din), 32'h03);
    chk("abort_bc", 32'(byte_count), 8);

    // Upload falling wins over a same-cycle rd.
    start_session(2);
    p0 = pulses;
    hps.ioctl_rd = 1'b1;
    hps.ioctl_addr = 25'h005;
    hps.ioctl_upload = 1'b0;
    pause_ack = 1'b0;
    tick();
    hps.ioctl_rd = 1'b0;
    chk("prec_pause", 32'(pause_req), 0);
    chk("prec_mem_rd", 32'(mem_rd), 0);
    tick();
    tick();
    chk("prec_pulses", 32'(pulses - p0), 0);
    chk("prec_din", 32'(hps.ioctl_din), 32'h03);
    chk("prec_bc", 32'(byte_count), 0);

    // Index changing mid-session aborts.
    start_session(1);
    hps.ioctl_index = 8'd5;
    tick();
    chk("idx_abort_pause", 32'(pause_req), 0);
    chk("idx_abort_wait", 32'(hps.ioctl_wait), 0);
    end_session();

    // Ack timeout.
    hps.ioctl_upload = 1'b1;
    hps.ioctl_index  = 8'd4;
    tick();
    n = 0;
    while (hps.ioctl_wait && n < 5000) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 4096);
    chk("timeout_flag", 32'(ack_timeout), 1);
    chk("timeout_pause_held", 32'(pause_req), 1);
    end_session();
    chk("timeout_sticky", 32'(ack_timeout), 1);

    // byte_count saturation.
    start_session(1);
    for (int i = 0; i < 1024; i++) begin
      hps.ioctl_rd = 1'b1;
      hps.ioctl_addr = 25'h000;
      tick();
      hps.ioctl_rd = 1'b0;
      tick();
      tick();
    end
    chk("sat_bc_1024", 32'(byte_count), 1024);
    bc_exp = 1024;
    do_read(25'h005, 8'hA5, 1);
    do_read(25'h000, 8'h03, 1);
    chk("sat_bc_hold", 32'(byte_count), 1024);

    // Reset in the middle of CAPTURE takes effect before the next edge.
    hps.ioctl_rd = 1'b1;
    hps.ioctl_addr = 25'h005;
    tick();
    hps.ioctl_rd = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_din", 32'(hps.ioctl_din), 0);
    chk("mid_rst_wait", 32'(hps.ioctl_wait), 0);
    chk("mid_rst_pause", 32'(pause_req), 0);
    chk("mid_rst_mem_rd", 32'(mem_rd), 0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 0);
    chk("mid_rst_ack_to", 32'(ack_timeout), 0);
    chk("mid_rst_bc", 32'(byte_count), 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("post_rst_no_start", 32'(pause_req), 0);
    chk("post_rst_din", 32'(hps.ioctl_din), 0);
    hps.ioctl_upload = 1'b0;
    tick();
    hps.ioctl_upload = 1'b1;
    tick();
    chk("post_rst_fresh_start", 32'(pause_req), 1);
    end_session();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
